// File: rtl/vec_sqsum_acc_if.sv
// Handshake bundle between the vector ALU result stream, the accumulator
// and the writeback stage: element input channel plus result output channel.
interface vec_sqsum_acc_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_sum;
  logic              res_ovf;
  logic [CNT_W-1:0]  res_cnt;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_sum, res_ovf, res_cnt
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_sum, res_ovf, res_cnt
  );
endinterface

// File: rtl/vec_sqsum_acc.sv
// Accumulates a programmable number of sum-of-squares ALU results and hands
// the wrapped total, sticky carry flag and element count to writeback.
module vec_sqsum_acc #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] vlen_i,
  output logic             busy_o,
  vec_sqsum_acc_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W:0]   sum;

  // Extra top bit captures the unsigned carry-out for the sticky flag.
  assign sum = {1'b0, acc_q} + {1'b0, bus.in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          rem_d   = vlen_i;
          state_d = (vlen_i == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        // in_ready is high throughout ACC, so in_valid alone means acceptance.
        if (bus.in_valid) begin
          acc_d = sum[DATA_W-1:0];
          ovf_d = ovf_q | sum[DATA_W];
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs come from registered state only; results from the
  // accumulator registers, which hold after the result is consumed.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.res_valid = (state_q == OUT);
  assign busy_o        = (state_q != IDLE);
  assign bus.res_sum   = acc_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_cnt   = cnt_q;

endmodule

// File: tb/tb_vec_sqsum_acc.sv
// Scoreboard bench for vec_sqsum_acc: expected reductions are queued when a
// reduction starts and compared whenever the result handshake fires.
module tb_vec_sqsum_acc;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;
  } res_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] vlen;
  logic             busy;

  vec_sqsum_acc_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  vec_sqsum_acc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .vlen_i  (vlen),
    .busy_o  (busy),
    .bus     (bus)
  );

  res_t              expQ[$];
  res_t              monExp;
  logic [DATA_W-1:0] dataBuf[8];
  int                errors = 0;
  int                checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    checkOutput({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    checkOutput({tag, "_res_sum"}, 64'(bus.res_sum), 64'd0);
    checkOutput({tag, "_res_ovf"}, 64'(bus.res_ovf), 64'd0);
    checkOutput({tag, "_res_cnt"}, 64'(bus.res_cnt), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Queue the reference result, start the reduction, feed dataBuf following
  // validPat (bit i = in_valid on feed cycle i) and wait until back in IDLE.
  task automatic applyStimulus(input int n, input logic [15:0] validPat);
    logic [DATA_W:0] s;
    res_t            e;
    int              k;
    int              cyc;
    s     = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s     = {1'b0, s[DATA_W-1:0]} + {1'b0, dataBuf[i]};
      e.ovf = e.ovf | s[DATA_W];
    end
    e.sum = s[DATA_W-1:0];
    e.cnt = n[CNT_W-1:0];
    expQ.push_back(e);
    start = 1'b1;
    vlen  = n[CNT_W-1:0];
    tick();
    start = 1'b0;
    k     = 0;
    cyc   = 0;
    while (k < n && cyc < 200) begin
      bus.in_valid = (cyc < 16) ? validPat[cyc] : 1'b1;
      bus.in_data  = bus.in_valid ? dataBuf[k] : 32'hDEAD_BEEF;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) k++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    checkOutput("feed_count", 64'(k), 64'(n));
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_busy", 64'(busy), 64'd0);
    tick();
  endtask

  // Result monitor: a handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_res_valid", 64'd1, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("res_sum", 64'(bus.res_sum), 64'(monExp.sum));
        checkOutput("res_ovf", 64'(bus.res_ovf), 64'(monExp.ovf));
        checkOutput("res_cnt", 64'(bus.res_cnt), 64'(monExp.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] sq [4];
    sq[0] = 16'd1; sq[1] = 16'd4; sq[2] = 16'd9; sq[3] = 16'd16;
    rst           = 1'b1;
    start         = 1'b0;
    vlen          = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkIdleOutputs("reset");
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] basic vlen=4 timing");
    bus.res_ready = 1'b1;
    expQ.push_back('{sum: 32'd30, ovf: 1'b0, cnt: 6'd4});
    start = 1'b1;
    vlen  = 6'd4;
    @(negedge clk);
    checkOutput("t1_in_ready_c0", 64'(bus.in_ready), 64'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(sq[i]);
      @(negedge clk);
      checkOutput("t1_in_ready_acc", 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_res_valid_c5", 64'(bus.res_valid), 64'd1);
    checkOutput("t1_busy_c5", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("t1_res_valid_c6", 64'(bus.res_valid), 64'd0);
    checkOutput("t1_busy_c6", 64'(busy), 64'd0);
    tick();

    $display("[TB] gapped input vlen=3");
    dataBuf[0] = 32'h10; dataBuf[1] = 32'h20; dataBuf[2] = 32'h30;
    applyStimulus(3, 16'b0000_0000_0010_1001);

    $display("[TB] overflow then fresh reduction");
    dataBuf[0] = 32'hFFFF_FFF0; dataBuf[1] = 32'h20;
    applyStimulus(2, 16'hFFFF);
    dataBuf[0] = 32'd5;
    applyStimulus(1, 16'hFFFF);

    $display("[TB] vlen=0 with result held");
    bus.res_ready = 1'b0;
    expQ.push_back('{sum: 32'd0, ovf: 1'b0, cnt: 6'd0});
    start = 1'b1;
    vlen  = 6'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t4_res_valid_hold", 64'(bus.res_valid), 64'd1);
      checkOutput("t4_in_ready_hold", 64'(bus.in_ready), 64'd0);
      checkOutput("t4_res_sum_hold", 64'(bus.res_sum), 64'd0);
      checkOutput("t4_res_ovf_hold", 64'(bus.res_ovf), 64'd0);
      checkOutput("t4_res_cnt_hold", 64'(bus.res_cnt), 64'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("t4_busy_after", 64'(busy), 64'd0);
    tick();

    $display("[TB] start ignored during ACC");
    expQ.push_back('{sum: 32'h33, ovf: 1'b0, cnt: 6'd2});
    start = 1'b1;
    vlen  = 6'd2;
    tick();
    vlen         = 6'd7;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h11;
    tick();
    start       = 1'b0;
    bus.in_data = 32'h22;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_res_valid", 64'(bus.res_valid), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("t5_busy_after", 64'(busy), 64'd0);
    tick();

    $display("[TB] reset mid-reduction");
    start = 1'b1;
    vlen  = 6'd5;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd100;
    tick();
    bus.in_data = 32'd200;
    tick();
    rst         = 1'b1;
    bus.in_data = 32'd300;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkIdleOutputs("t6_after_rst");
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t6_no_res_valid", 64'(bus.res_valid), 64'd0);
      tick();
    end
    dataBuf[0] = 32'd7;
    applyStimulus(1, 16'hFFFF);

    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
